// File: rtl/dpm_pkg.sv
// Shared types and constants for the narrow-side stream reader.
// Holds the FSM state type, the RAM read-latency helper and the word-buffer depth.
// No logic of its own; imported by the reader and its word buffer.
package dpm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dpm_rd_state_t;

  localparam int DPM_RD_BUF_DEPTH = 2;

  // RAM read latency: an output register adds one cycle
  function automatic int dpm_rd_latency(input logic [7:0] regout);
    return (regout == "Y") ? 2 : 1;
  endfunction

endpackage

// File: rtl/dpm_wbuf.sv
// Two-entry word FIFO holding RAM words until every lane has been streamed out.
// Latency: a pushed word is visible at the head on the next cycle.
// Backpressure: none internally; the reader only issues reads it has room for.
module dpm_wbuf
  import dpm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] mem [DPM_RD_BUF_DEPTH];
  logic         wptr;
  logic         rptr;

  assign head  = mem[rptr];
  assign empty = (count == 2'd0);

  // Storage, pointers and occupancy; flush drops contents but keeps stale data bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DPM_RD_BUF_DEPTH; i++) mem[i] <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/dpm_stream_reader.sv
// Fetches len wide RAM words from base_addr and streams them as narrow beats, lane 0 first.
// Latency: first m_valid L+2 cycles after start; 1 beat/cycle sustained when m_ready is high.
// Backpressure: m_ready stalls the lane counter; reads are issued only when buffer room is assured.
// Optional abort input enabled by DPM_STREAM_READER_ABORT_EN.
module dpm_stream_reader
  import dpm_pkg::*;
#(
  parameter int         FDWIDTH = 32,
  parameter int         FAWIDTH = 8,
  parameter int         SDWIDTH = 8,
  parameter logic [7:0] REGOUT  = "Y"
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FAWIDTH-1:0] base_addr,
  input  logic [FAWIDTH:0]   len,
`ifdef DPM_STREAM_READER_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [FAWIDTH-1:0] ram_addr,
  output logic               ram_rd,
  input  logic [FDWIDTH-1:0] ram_q,
  output logic [SDWIDTH-1:0] m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready
);

  localparam int RATIO = FDWIDTH / SDWIDTH;
  localparam int LW    = $clog2(RATIO);
  localparam int LAT   = dpm_rd_latency(REGOUT);

  dpm_rd_state_t      state;
  logic [FAWIDTH:0]   rem;
  logic [FAWIDTH:0]   len_q;
  logic [FAWIDTH:0]   word_cnt;
  logic [LW-1:0]      lane;
  logic [1:0]         inflight;
  logic [LAT-1:0]     rd_pipe;
  logic [FDWIDTH-1:0] head;
  logic [1:0]         buf_cnt;
  logic               buf_empty;
  logic               abort_i;
  logic               kill;
  logic               hs;
  logic               lane_end;
  logic               pop;
  logic               push;
  logic [2:0]         occ;

`ifdef DPM_STREAM_READER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign kill     = abort_i && (state == ST_RUN || state == ST_DRAIN);
  assign m_valid  = !buf_empty;
  assign hs       = m_valid && m_ready;
  assign lane_end = (lane == LW'(RATIO - 1));
  assign pop      = hs && lane_end;
  assign push     = rd_pipe[LAT-1];
  assign m_data   = head[int'(lane)*SDWIDTH +: SDWIDTH];
  assign m_last   = m_valid && lane_end && (word_cnt == len_q - 1'b1);

  // Words held plus words in flight, counting the slot freed by a pop this cycle
  assign occ    = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
  assign ram_rd = (state == ST_RUN) && (rem != '0) && !kill && (occ < 3'(DPM_RD_BUF_DEPTH));

  dpm_wbuf #(.W(FDWIDTH)) u_wbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (kill),
    .push  (push && !kill),
    .wdata (ram_q),
    .pop   (pop),
    .head  (head),
    .count (buf_cnt),
    .empty (buf_empty)
  );

  // Run control: latch the request, walk the address, and pulse done at the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_addr <= '0;
      rem      <= '0;
      len_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ram_addr <= base_addr;
            rem      <= len;
            len_q    <= len;
            if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (kill) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (ram_rd) begin
            ram_addr <= ram_addr + 1'b1;
            rem      <= rem - 1'b1;
            if (rem == (FAWIDTH+1)'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (kill || (hs && m_last)) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-return tracking: one pipe bit per cycle of RAM latency, plus outstanding count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe  <= '0;
      inflight <= 2'd0;
    end else if (kill) begin
      rd_pipe  <= '0;
      inflight <= 2'd0;
    end else begin
      rd_pipe  <= (rd_pipe << 1) | LAT'(ram_rd);
      inflight <= inflight + 2'(ram_rd) - 2'(push);
    end
  end

  // Lane and word position of the beat currently presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= '0;
      word_cnt <= '0;
    end else if (kill || (state == ST_IDLE && start)) begin
      lane     <= '0;
      word_cnt <= '0;
    end else if (hs) begin
      lane <= lane + 1'b1;
      if (lane_end) word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dpm_stream_reader.sv
// Randomised bench for dpm_stream_reader: sync RAM stub with 2-cycle latency,
// expected beat stream built from RAM contents, checks on order, stalls, timing and occupancy.
// Abort scenario included when DPM_STREAM_READER_ABORT_EN is defined.
module tb_dpm_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  len = '0;
  logic        abort = 1'b0;
  logic        busy, done, ram_rd, m_valid, m_last;
  logic [7:0]  ram_addr;
  logic [31:0] ram_q = '0;
  logic [31:0] ram_s1 = '0;
  logic [7:0]  m_data;
  logic        m_ready = 1'b1;

  logic [31:0] mem [256];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dpm_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
`ifdef DPM_STREAM_READER_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_q     (ram_q),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  // Synchronous RAM stub with output register (read latency 2)
  always @(posedge clk) begin
    ram_s1 <= mem[ram_addr];
    ram_q  <= ram_s1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cut: 0 = run to completion, 1 = reset after cut_at beats, 2 = abort while beat cut_at is presented
  task automatic run_xfer(input int base, input int n, input int pct, input bit inj,
                          input int cut, input int cut_at,
                          output int beats, output int first_v, output int last_hs, output int max_occ);
    logic [7:0]  eb [$];
    logic        el [$];
    logic [31:0] wd;
    logic [7:0]  pd;
    logic        pl;
    bit          stall, fin, aborted;
    int          issued, popped, cyc;
    issued = 0; popped = 0; beats = 0; first_v = -1; last_hs = -1; max_occ = 0;
    stall = 0; fin = 0; aborted = 0; pd = '0; pl = 1'b0;
    for (int w = 0; w < n; w++) begin
      wd = mem[(base + w) % 256];
      for (int b = 0; b < 4; b++) begin
        eb.push_back(wd[8*b +: 8]);
        el.push_back(w == n - 1 && b == 3);
      end
    end
    if (n == 0) last_hs = 0;
    base_addr = base[7:0];
    len = n[8:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 3000 && !fin; cyc++) begin
      m_ready = ($urandom_range(99) < pct);
      start = (inj && cyc == 3);
      if (start) len = 9'd5;
      if (cut == 1 && beats == cut_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", {busy, done, ram_addr, ram_rd, m_data, m_valid, m_last}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1;
      end else if (cut == 2 && aborted) begin
        abort = 1'b0;
        #1;
        chk("abort_valid", m_valid, 0);
        chk("abort_done", done, 1);
        chk("abort_busy", busy, 0);
        fin = 1;
      end else begin
        if (cut == 2 && beats == cut_at) begin
          abort = 1'b1;
          m_ready = 1'b0;
          aborted = 1;
        end
        #1;
        if (last_hs >= 0) begin
          chk("done_pulse", done, 1);
          chk("done_busy", busy, 0);
          chk("done_valid", m_valid, 0);
          fin = 1;
        end else begin
          if (cyc == 1) chk("busy_c1", busy, 1);
          if (stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, pd);
            chk("stall_last", m_last, pl);
          end
          if (ram_rd) begin
            chk("rd_addr", ram_addr, (base + issued) % 256);
            issued++;
          end
          if (m_valid && first_v < 0) first_v = cyc;
          if (m_valid && m_ready) begin
            if (beats < eb.size()) begin
              chk("beat_data", m_data, eb[beats]);
              chk("beat_last", m_last, el[beats]);
              if (el[beats]) last_hs = cyc;
            end else begin
              chk("extra_beat", 1, 0);
            end
            beats++;
            if (beats % 4 == 0) popped++;
          end
          if (issued - popped > max_occ) max_occ = issued - popped;
          stall = m_valid && !m_ready;
          pd = m_data;
          pl = m_last;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    m_ready = 1'b1;
    if (!fin) chk("timeout", 0, 1);
    if (cut == 0) chk("issued_total", issued, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, fv, lh, mo, bad;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h44332211;
    mem[8'h11] = 32'h88776655;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rd", ram_rd, 0);
    chk("rst_valid_data_last", {m_valid, m_data, m_last}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run: 8 beats back-to-back from cycle 4, done in cycle 12
    run_xfer(8'h10, 2, 100, 0, 0, 0, beats, fv, lh, mo);
    chk("basic_beats", beats, 8);
    chk("basic_first_valid", fv, 4);
    chk("basic_last_cycle", lh, 11);

    // Address wrap
    run_xfer(8'hFF, 3, 100, 0, 0, 0, beats, fv, lh, mo);
    chk("wrap_beats", beats, 12);

    // Backpressure
    run_xfer($urandom_range(255), 16, 30, 0, 0, 0, beats, fv, lh, mo);
    chk("bp_beats", beats, 64);
    chk("bp_occ_ok", mo <= 2, 1);

    // Empty run
    run_xfer(8'h40, 0, 100, 0, 0, 0, beats, fv, lh, mo);
    chk("empty_no_valid", fv, -1);
    chk("empty_beats", beats, 0);

    // start pulsed mid-run is ignored
    run_xfer($urandom_range(255), 3, 70, 1, 0, 0, beats, fv, lh, mo);
    chk("inj_beats", beats, 12);

    // Reset after beat 5, then a clean single-word run
    run_xfer($urandom_range(255), 8, 100, 0, 1, 5, beats, fv, lh, mo);
    run_xfer($urandom_range(255), 1, 100, 0, 0, 0, beats, fv, lh, mo);
    chk("post_reset_beats", beats, 4);

`ifdef DPM_STREAM_READER_ABORT_EN
    run_xfer($urandom_range(255), 4, 100, 0, 2, 2, beats, fv, lh, mo);
    bad = 0;
    repeat (6) begin
      if (m_valid) bad++;
      @(negedge clk);
    end
    chk("abort_late_returns", bad, 0);
    run_xfer($urandom_range(255), 2, 100, 0, 0, 0, beats, fv, lh, mo);
    chk("post_abort_beats", beats, 8);
`else
    bad = 0;
`endif

    // Random runs
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 9);
      run_xfer($urandom_range(255), n, $urandom_range(20, 100), 0, 0, 0, beats, fv, lh, mo);
      chk("rand_beats", beats, 4 * n);
      chk("rand_occ_ok", mo <= 2, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
